// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive-side array collector.
// Holds the byte width, the oversample ratio and the collector state encoding.
package uart_pkg;

  localparam int UART_BYTE_W  = 8;
  localparam int OVERSAMPLE   = 16;
  localparam int TIMEOUT_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } state_t;

endpackage

// File: rtl/uart_byte_ram.sv
// Byte storage for one frame.
// One synchronous write port and one combinational read port.
module uart_byte_ram
  import uart_pkg::*;
#(
  parameter int DEPTH = 13,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_waddr,
  input  logic [UART_BYTE_W-1:0] i_wdata,
  input  logic [AW-1:0]          i_raddr,
  output logic [UART_BYTE_W-1:0] o_rdata
);

  logic [UART_BYTE_W-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset; every location is written before it is read, and a
  // reset here would stop the tools from mapping it onto RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_array_collector.sv
// Gathers UART_Rx bytes into a frame closed by count or idle timeout,
// then streams the frame out in arrival order over a valid/ready port.
module uart_rx_array_collector
  import uart_pkg::*;
#(
  parameter int ARRAY_LEN     = 13,
  parameter int TIMEOUT_TICKS = TIMEOUT_BITS * OVERSAMPLE,
  parameter int LEN_W         = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pulse_rx,
  input  logic                   rx_val,
  input  logic [UART_BYTE_W-1:0] rx_data,
  output logic                   out_val,
  output logic [UART_BYTE_W-1:0] out_data,
  output logic                   out_last,
  input  logic                   out_rdy,
  output logic [LEN_W-1:0]       frame_len,
  output logic                   frame_to,
  output logic                   overrun
);

  localparam int                 CNT_W   = $clog2(TIMEOUT_TICKS + 1);
  localparam int                 RAM_AW  = (ARRAY_LEN > 1) ? $clog2(ARRAY_LEN) : 1;
  localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(ARRAY_LEN);
  localparam logic [CNT_W-1:0]   TO_MAX  = CNT_W'(TIMEOUT_TICKS);

  state_t                 r_state, w_state_nxt;
  logic                   r_rx_val_d;
  logic [LEN_W-1:0]       r_wr_idx, r_rd_idx;
  logic [CNT_W-1:0]       r_idle_cnt;
  logic                   r_out_val, r_out_last, r_frame_to, r_overrun;
  logic [UART_BYTE_W-1:0] r_out_data;
  logic [LEN_W-1:0]       r_frame_len;

  logic                   w_capture;
  logic [LEN_W-1:0]       w_wr_idx_inc, w_rd_idx_inc, w_last_idx;
  logic [CNT_W-1:0]       w_idle_inc;
  logic [UART_BYTE_W-1:0] w_rd_data;
  logic w_wr_en, w_tick, w_close_cnt, w_close_to, w_present, w_advance, w_done, w_overrun;

  assign w_capture    = rx_val & ~r_rx_val_d;
  assign w_wr_idx_inc = r_wr_idx + LEN_W'(1);
  assign w_rd_idx_inc = r_rd_idx + LEN_W'(1);
  assign w_last_idx   = r_frame_len - LEN_W'(1);
  assign w_idle_inc   = (r_idle_cnt == TO_MAX) ? r_idle_cnt : r_idle_cnt + CNT_W'(1);

  uart_byte_ram #(
    .DEPTH (ARRAY_LEN),
    .AW    (RAM_AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_idx[RAM_AW-1:0]),
    .i_wdata (rx_data),
    // While a beat is presented, look ahead to the next byte so beats can go back to back.
    .i_raddr (r_out_val ? w_rd_idx_inc[RAM_AW-1:0] : r_rd_idx[RAM_AW-1:0]),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // NOTE: every signal gets its default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_tick      = 1'b0;
    w_close_cnt = 1'b0;
    w_close_to  = 1'b0;
    w_present   = 1'b0;
    w_advance   = 1'b0;
    w_done      = 1'b0;
    w_overrun   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_capture) begin
          w_wr_en     = 1'b1;
          w_state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (w_capture) begin
          w_wr_en = 1'b1;
          if (w_wr_idx_inc == LEN_MAX) begin
            w_close_cnt = 1'b1;
            w_state_nxt = DRAIN;
          end
        end else if (pulse_rx) begin
          w_tick = 1'b1;
          if (w_idle_inc == TO_MAX) begin
            w_close_to  = 1'b1;
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        w_overrun = w_capture;
        if (!r_out_val) begin
          w_present = 1'b1;
        end else if (out_rdy) begin
          if (r_out_last) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_val_d  <= 1'b0;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_idle_cnt  <= '0;
      r_out_val   <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_frame_len <= '0;
      r_frame_to  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_rx_val_d <= rx_val;
      r_overrun  <= w_overrun;
      if (w_wr_en) begin
        r_wr_idx   <= w_wr_idx_inc;
        r_idle_cnt <= '0;
      end else if (w_tick) begin
        r_idle_cnt <= w_idle_inc;
      end
      if (w_close_cnt) begin
        r_frame_len <= LEN_MAX;
        r_frame_to  <= 1'b0;
      end else if (w_close_to) begin
        r_frame_len <= r_wr_idx;
        r_frame_to  <= 1'b1;
      end
      if (w_present) begin
        r_out_val  <= 1'b1;
        r_out_data <= w_rd_data;
        r_out_last <= (r_rd_idx == w_last_idx);
      end else if (w_advance) begin
        r_rd_idx   <= w_rd_idx_inc;
        r_out_data <= w_rd_data;
        r_out_last <= (w_rd_idx_inc == w_last_idx);
      end else if (w_done) begin
        r_out_val  <= 1'b0;
        r_out_last <= 1'b0;
        r_wr_idx   <= '0;
        r_rd_idx   <= '0;
        r_idle_cnt <= '0;
      end
    end
  end

  assign out_val   = r_out_val;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign frame_len = r_frame_len;
  assign frame_to  = r_frame_to;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_array_collector.sv
// Directed bench for uart_rx_array_collector: a table of frames with expected beats,
// plus hand-written reset and overrun sequences.
module tb_uart_rx_array_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pulse_rx = 1'b0;
  logic       rx_val = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       out_val, out_last, out_rdy = 1'b0, frame_to, overrun;
  logic [7:0] out_data;
  logic [7:0] frame_len;

  int n_checks = 0;
  int n_errors = 0;
  int tb_ticks = 0;
  int ov_cnt   = 0;
  logic rx_val_q = 1'b0;

  typedef struct {
    logic [103:0] data;      // byte 0 in the top octet
    int           n;
    int           hold;      // cycles rx_val is held for the first byte
    bit           rdy_rand;
    int           exp_len;
    logic         exp_to;
  } vec_t;

  vec_t tbl [5];

  uart_rx_array_collector dut (
    .clk       (clk),
    .rst       (rst),
    .pulse_rx  (pulse_rx),
    .rx_val    (rx_val),
    .rx_data   (rx_data),
    .out_val   (out_val),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_rdy   (out_rdy),
    .frame_len (frame_len),
    .frame_to  (frame_to),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Oversample tick once every 4 clocks keeps the 160-tick timeout short.
  initial begin
    int div = 0;
    forever begin
      @(negedge clk);
      pulse_rx = (div == 0);
      div = (div + 1) % 4;
    end
  end

  // Idle ticks since the last rx_val rising edge, as seen on the line.
  always @(posedge clk) begin
    rx_val_q <= rx_val;
    if (rx_val && !rx_val_q) tb_ticks <= 0;
    else if (pulse_rx)       tb_ticks <= tb_ticks + 1;
  end

  always @(negedge clk) if (overrun) ov_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_val  = 1'b1;
    rx_data = b;
    repeat (hold) @(negedge clk);
    rx_val = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input vec_t v);
    for (int i = 0; i < v.n; i++)
      send_byte(v.data[(12 - i) * 8 +: 8], (i == 0) ? v.hold : 1);
  endtask

  task automatic wait_val(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      seen = out_val;
    end
  endtask

  task automatic receive_frame(input vec_t v);
    int   beat = 0;
    int   cyc  = 0;
    bit   first_seen = 1'b0;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic prev_last = 1'b0;
    while (beat < v.exp_len && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (out_val) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          if (v.exp_to) check("timeout_ticks", tb_ticks, 160);
        end
        if (prev_stall) begin
          check("stall_data", out_data, prev_data);
          check("stall_last", out_last, prev_last);
        end
        out_rdy = v.rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_rdy) begin
          check("beat_data", out_data, v.data[(12 - beat) * 8 +: 8]);
          check("beat_last", out_last, (beat == v.exp_len - 1));
          check("frame_len", frame_len, v.exp_len);
          check("frame_to", frame_to, v.exp_to);
          beat++;
        end
        prev_stall = !out_rdy;
        prev_data  = out_data;
        prev_last  = out_last;
      end else begin
        out_rdy = 1'b0;
      end
    end
    if (beat < v.exp_len) check("frame_beats_in_time", beat, v.exp_len);
    @(negedge clk);
    out_rdy = 1'b0;
    check("val_drop", out_val, 1'b0);
  endtask

  initial begin
    bit seen;
    int ov0;
    int stray;

    tbl[0] = '{104'h4d696b726f2d5461736172696d, 13, 1, 1'b0, 13, 1'b0};
    tbl[1] = '{{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 64'h0}, 5, 1, 1'b0, 5, 1'b1};
    tbl[2] = '{104'hF0E1D2C3B4A5968778695A4B3C, 13, 1, 1'b1, 13, 1'b0};
    tbl[3] = '{{8'hA5, 8'h5A, 88'h0}, 2, 1, 1'b1, 2, 1'b1};
    tbl[4] = '{{8'h77, 8'h88, 88'h0}, 2, 3, 1'b0, 2, 1'b1};

    // Reset values while rst is held low.
    repeat (3) @(negedge clk);
    check("rst_out_val", out_val, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_last", out_last, 1'b0);
    check("rst_frame_len", frame_len, 8'h00);
    check("rst_frame_to", frame_to, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst = 1'b1;

    // Abort mid-collect.
    for (int i = 0; i < 3; i++) send_byte(8'h30 + 8'(i), 1);
    rst = 1'b0;
    #1;
    check("collect_rst_val", out_val, 1'b0);
    check("collect_rst_len", frame_len, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // Abort mid-drain: the stalled first beat must vanish at once.
    send_frame(tbl[0]);
    wait_val(seen);
    check("drain_seen", seen, 1'b1);
    check("drain_len_before_rst", frame_len, 8'd13);
    rst = 1'b0;
    #1;
    check("drain_rst_val", out_val, 1'b0);
    check("drain_rst_data", out_data, 8'h00);
    check("drain_rst_len", frame_len, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // Idle line after release: longer than a timeout, nothing may come out.
    stray = 0;
    repeat (800) begin
      @(negedge clk);
      if (out_val || overrun) stray++;
    end
    check("idle_no_output", stray, 0);

    for (int t = 0; t < 5; t++) begin
      send_frame(tbl[t]);
      receive_frame(tbl[t]);
    end

    // Overrun: bytes arriving while the frame is stalled are dropped.
    send_frame(tbl[0]);
    wait_val(seen);
    check("ovr_drain_seen", seen, 1'b1);
    ov0 = ov_cnt;
    send_byte(8'hEE, 1);
    send_byte(8'hEF, 1);
    repeat (2) @(negedge clk);
    check("ovr_pulses", ov_cnt - ov0, 2);
    receive_frame(tbl[0]);
    check("ovr_total_after_drain", ov_cnt - ov0, 2);

    // Normal collection resumes after the overrun drain.
    send_frame(tbl[1]);
    receive_frame(tbl[1]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
